// File: rtl/ptw_arb_pkg.sv
// Shared types and helpers for the page-table-walk arbiter.
package ptw_arb_pkg;

  // Arbiter FSM: either waiting for a request or holding one DCache transaction.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Index width for n masters. Never zero, so single-bit indices stay legal.
  function automatic int IDX_W(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ptw_rr_picker.sv
// Combinational winner selection for the PTW arbiter.
// The request vector is duplicated and the low copy is masked below the
// round-robin pointer. The lowest set bit of the result is the first requester
// at or after the pointer, with wrap-around. Fixed mode pins the pointer at 0.
module ptw_rr_picker
  import ptw_arb_pkg::*;
#(
  parameter int N       = 2,
  parameter bit RR_MODE = 1'b1,
  parameter int W       = IDX_W(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] rr_ptr_i,
  output logic [W-1:0] winner_o,
  output logic         any_req_o
);

  logic [W-1:0]   base;
  logic [N-1:0]   low_mask;
  logic [2*N-1:0] dbl_masked;
  logic           found;

  assign base      = RR_MODE ? rr_ptr_i : '0;
  assign any_req_o = |req_i;

  // Enable only the low-copy positions at or above the search base.
  always_comb begin
    low_mask = '0;
    for (int j = 0; j < N; j++) begin
      low_mask[j] = (W'(j) >= base);
    end
  end

  assign dbl_masked = {req_i, req_i & low_mask};

  // Lowest set bit of the doubled vector, folded back into the range 0..N-1.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path through
    // this block can leave a value held over from the previous evaluation
    // (which would infer a latch).
    winner_o = '0;
    found    = 1'b0;
    for (int j = 0; j < 2 * N; j++) begin
      if (!found && dbl_masked[j]) begin
        found    = 1'b1;
        winner_o = (j >= N) ? W'(j - N) : W'(j);
      end
    end
  end

endmodule

// File: rtl/ptw_rr_arbiter.sv
// N-master page-table-walk arbiter in front of the single DCache PTW port.
// One transaction is held from grant to the DCache ack. An IDLE cycle always
// separates two downstream requests. A master that drops its request while its
// transaction is in flight loses the ack, but the DCache handshake still runs
// to completion.
module ptw_rr_arbiter
  import ptw_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter bit RR_MODE     = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            up_req_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] up_addr_i,
  output logic [DATA_WIDTH-1:0]             up_data_o,
  output logic [NUM_MASTERS-1:0]            up_ack_o,
  output logic                              dn_req_o,
  output logic [ADDR_WIDTH-1:0]             dn_addr_o,
  input  logic [DATA_WIDTH-1:0]             dn_data_i,
  input  logic                              dn_ack_i,
  output logic [$clog2(NUM_MASTERS)-1:0]    owner_o,
  output logic                              busy_o
);

  localparam int IW = IDX_W(NUM_MASTERS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MASTERS - 1);

  state_e                state_q, state_d;
  logic [IW-1:0]         owner_q, owner_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  abort_q, abort_d;
  logic [IW-1:0]         winner;
  logic                  any_req;
  logic                  busy;
  logic                  aborted;

  ptw_rr_picker #(
    .N       (NUM_MASTERS),
    .RR_MODE (RR_MODE),
    .W       (IW)
  ) u_picker (
    .req_i     (up_req_i),
    .rr_ptr_i  (rr_ptr_q),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  assign busy = (state_q == BUSY);

  // A drop of the owner's request in the ack cycle itself must also kill the ack.
  assign aborted = abort_q | ~up_req_i[owner_q];

  // Next-state: grant in IDLE, then track the abort and wait for the DCache ack in BUSY.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    abort_d  = abort_q;
    case (state_q)
      IDLE: begin
        // A stray ack here is ignored, because there is nothing to complete.
        if (any_req) begin
          state_d = BUSY;
          owner_d = winner;
          addr_d  = up_addr_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
          abort_d = 1'b0;
        end
      end
      BUSY: begin
        if (!up_req_i[owner_q]) abort_d = 1'b0 | 1'b1;
        if (dn_ack_i) begin
          state_d = IDLE;
          // Explicit compare wrap, because IW-bit truncation is wrong for non-power-of-two N.
          if (RR_MODE) rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; asynchronous reset drops any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      addr_q   <= '0;
      abort_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register here samples the
      // pre-edge values of the others, whatever order the statements are in.
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      abort_q  <= abort_d;
    end
  end

  // Same-cycle ack passthrough to the owner unless it has abandoned the walk.
  always_comb begin
    up_ack_o = '0;
    if (busy && dn_ack_i && !aborted) up_ack_o[owner_q] = 1'b1;
  end

  assign up_data_o = dn_data_i;
  assign dn_req_o  = busy;
  assign dn_addr_o = busy ? addr_q : '0;
  assign owner_o   = busy ? owner_q : '0;
  assign busy_o    = busy;

endmodule

// File: tb/tb_ptw_rr_arbiter.sv
// Self-checking bench for ptw_rr_arbiter. There are three instances:
// u0 (N=4, round-robin), u1 (N=4, fixed priority) and u2 (N=3, round-robin).
// Each instance is compared every cycle against a transaction-level model.
// Directed steps add explicit checks, and a random phase follows.
module tb_ptw_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_v  [3];
  logic [31:0] addr_v [3][4];
  logic        ack_v  [3];
  logic [31:0] data_v [3];

  logic        dn_req  [3];
  logic [31:0] dn_addr [3];
  logic [1:0]  owner   [3];
  logic        busy    [3];
  logic [31:0] up_data [3];
  logic [3:0]  ack0, ack1;
  logic [2:0]  ack2;

  // Behavioural model state, one entry per instance.
  int          m_busy  [3];
  int          m_owner [3];
  int          m_ptr   [3];
  int          m_abort [3];
  logic [31:0] m_addr  [3];

  // DCache responder and stimulus controls.
  int          cnt [3];
  int          lat [3];
  bit          ack_force [3];
  bit          data_fix  [3];
  bit          rand_mode;
  logic [3:0]  samp_ack [3];

  int n_assert = 0;
  int n_fail   = 0;

  ptw_rr_arbiter #(.NUM_MASTERS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_MODE(1'b1)) u0 (
    .clk(clk), .rst(rst), .up_req_i(req_v[0]),
    .up_addr_i({addr_v[0][3], addr_v[0][2], addr_v[0][1], addr_v[0][0]}),
    .up_data_o(up_data[0]), .up_ack_o(ack0), .dn_req_o(dn_req[0]), .dn_addr_o(dn_addr[0]),
    .dn_data_i(data_v[0]), .dn_ack_i(ack_v[0]), .owner_o(owner[0]), .busy_o(busy[0]));

  ptw_rr_arbiter #(.NUM_MASTERS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_MODE(1'b0)) u1 (
    .clk(clk), .rst(rst), .up_req_i(req_v[1]),
    .up_addr_i({addr_v[1][3], addr_v[1][2], addr_v[1][1], addr_v[1][0]}),
    .up_data_o(up_data[1]), .up_ack_o(ack1), .dn_req_o(dn_req[1]), .dn_addr_o(dn_addr[1]),
    .dn_data_i(data_v[1]), .dn_ack_i(ack_v[1]), .owner_o(owner[1]), .busy_o(busy[1]));

  ptw_rr_arbiter #(.NUM_MASTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_MODE(1'b1)) u2 (
    .clk(clk), .rst(rst), .up_req_i(req_v[2][2:0]),
    .up_addr_i({addr_v[2][2], addr_v[2][1], addr_v[2][0]}),
    .up_data_o(up_data[2]), .up_ack_o(ack2), .dn_req_o(dn_req[2]), .dn_addr_o(dn_addr[2]),
    .dn_data_i(data_v[2]), .dn_ack_i(ack_v[2]), .owner_o(owner[2]), .busy_o(busy[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [3:0] get_ack(input int i);
    case (i)
      0:       return ack0;
      1:       return ack1;
      default: return {1'b0, ack2};
    endcase
  endfunction

  function automatic int n_of(input int i);
    return (i == 2) ? 3 : 4;
  endfunction

  function automatic bit rr_of(input int i);
    return i != 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int i);
    m_busy[i]  = 0;
    m_owner[i] = 0;
    m_ptr[i]   = 0;
    m_abort[i] = 0;
    m_addr[i]  = '0;
  endtask

  // Arbitration rule: the first requester found when scanning from the pointer
  // with modulo-N wrap. In fixed mode the pointer never moves from 0.
  task automatic model_update(input int i);
    int n;
    n = n_of(i);
    if (m_busy[i] == 0) begin
      for (int k = 0; k < n; k++) begin
        int j;
        j = (m_ptr[i] + k) % n;
        if (req_v[i][j] && m_busy[i] == 0) begin
          m_busy[i]  = 1;
          m_owner[i] = j;
          m_addr[i]  = addr_v[i][j];
          m_abort[i] = 0;
        end
      end
    end else begin
      if (!req_v[i][m_owner[i]]) m_abort[i] = 1;
      if (ack_v[i]) begin
        m_busy[i] = 0;
        if (rr_of(i)) m_ptr[i] = (m_owner[i] + 1) % n;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      logic [3:0] e_ack;
      e_ack = 4'b0000;
      if (m_busy[i] != 0 && ack_v[i] && m_abort[i] == 0 && req_v[i][m_owner[i]])
        e_ack = 4'(1 << m_owner[i]);
      check($sformatf("u%0d.dn_req", i),  32'(dn_req[i]),  32'(m_busy[i] != 0));
      check($sformatf("u%0d.dn_addr", i), dn_addr[i],      (m_busy[i] != 0) ? m_addr[i] : 32'd0);
      check($sformatf("u%0d.owner", i),   32'(owner[i]),   (m_busy[i] != 0) ? 32'(m_owner[i]) : 32'd0);
      check($sformatf("u%0d.busy", i),    32'(busy[i]),    32'(m_busy[i] != 0));
      check($sformatf("u%0d.up_ack", i),  32'(get_ack(i)), 32'(e_ack));
      check($sformatf("u%0d.up_data", i), up_data[i],      data_v[i]);
    end
  endtask

  // Start of a cycle: the DCache responder reacts to the post-edge state.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (dn_req[i]) begin
        cnt[i]++;
        if (cnt[i] == 1 && rand_mode) lat[i] = $urandom_range(1, 4);
      end else begin
        cnt[i] = 0;
      end
      ack_v[i] = ack_force[i] || (dn_req[i] && cnt[i] == lat[i] + 1) ||
                 (rand_mode && !dn_req[i] && $urandom_range(0, 9) == 0);
      data_v[i] = data_fix[i] ? 32'hDEAD_BEEF : $urandom();
    end
  endtask

  // Middle of a cycle: compare against the model, then advance it past the next edge.
  task automatic settle();
    @(negedge clk);
    if (rst) for (int i = 0; i < 3; i++) model_reset(i);
    check_all();
    if (!rst) for (int i = 0; i < 3; i++) model_update(i);
    for (int i = 0; i < 3; i++) samp_ack[i] = get_ack(i);
  endtask

  task automatic cyc();
    tick();
    settle();
  endtask

  task automatic wait_grant(input int i);
    int n;
    n = 0;
    while (!dn_req[i] && n < 20) begin
      cyc();
      n++;
    end
    check($sformatf("u%0d.grant_seen", i), 32'(dn_req[i]), 32'd1);
  endtask

  task automatic wait_ack(input int i);
    int n;
    n = 0;
    while (get_ack(i) == 4'b0000 && n < 20) begin
      cyc();
      n++;
    end
  endtask

  initial begin
    rst       = 1'b1;
    rand_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_v[i]     = '0;
      ack_v[i]     = 1'b0;
      data_v[i]    = '0;
      cnt[i]       = 0;
      lat[i]       = 2;
      ack_force[i] = 1'b0;
      data_fix[i]  = 1'b0;
      samp_ack[i]  = '0;
      for (int j = 0; j < 4; j++) addr_v[i][j] = '0;
      model_reset(i);
    end
    settle();
    settle();
    tick(); rst = 1'b0; settle();
    check("reset.dn_req", 32'(dn_req[0]), 32'd0);
    check("reset.busy",   32'(busy[0]),   32'd0);
    check("reset.owner",  32'(owner[0]),  32'd0);
    check("reset.ack",    32'(ack0),      32'd0);

    // Single transaction: master 2, ack three cycles after dn_req rises.
    lat[0] = 3; data_fix[0] = 1'b1;
    tick(); req_v[0] = 4'b0100; addr_v[0][2] = 32'h8000_1000; settle();
    check("single.no_req_same_cycle", 32'(dn_req[0]), 32'd0);
    for (int c = 1; c <= 4; c++) begin
      cyc();
      check("single.dn_req",  32'(dn_req[0]), 32'd1);
      check("single.dn_addr", dn_addr[0],     32'h8000_1000);
      check("single.owner",   32'(owner[0]),  32'd2);
      check("single.ack",     32'(ack0),      (c == 4) ? 32'h4 : 32'h0);
    end
    check("single.data", up_data[0], 32'hDEAD_BEEF);
    tick(); req_v[0] = 4'b0000; settle();
    check("single.gap",      32'(dn_req[0]), 32'd0);
    check("single.ack_once", 32'(ack0),      32'd0);
    data_fix[0] = 1'b0;

    // Reset in the middle of a transaction, then a late ack from the DCache.
    lat[0] = 50;
    tick(); req_v[0] = 4'b0010; addr_v[0][1] = 32'hCAFE_0000; settle();
    cyc(); cyc();
    check("rst.busy_before", 32'(busy[0]), 32'd1);
    tick(); rst = 1'b1; req_v[0] = 4'b0000; settle();
    check("rst.dn_req",  32'(dn_req[0]),  32'd0);
    check("rst.dn_addr", dn_addr[0],      32'd0);
    check("rst.owner",   32'(owner[0]),   32'd0);
    check("rst.busy",    32'(busy[0]),    32'd0);
    ack_force[0] = 1'b1;
    tick(); rst = 1'b0; settle();
    check("rst.late_ack", 32'(ack0), 32'd0);
    ack_force[0] = 1'b0;
    cyc();
    check("rst.stays_idle", 32'(busy[0]), 32'd0);

    // Round-robin fairness: all four masters request continuously.
    lat[0] = 2;
    tick();
    req_v[0] = 4'b1111;
    for (int j = 0; j < 4; j++) addr_v[0][j] = 32'h4000_0000 + 32'(j * 16);
    settle();
    for (int t = 0; t < 5; t++) begin
      wait_grant(0);
      check("rr.owner", 32'(owner[0]), 32'(t % 4));
      check("rr.addr",  dn_addr[0],    32'h4000_0000 + 32'((t % 4) * 16));
      wait_ack(0);
      check("rr.ack", 32'(ack0), 32'(1 << (t % 4)));
      if (t < 4) begin
        int low;
        cyc();
        low = 0;
        while (!dn_req[0] && low < 8) begin
          low++;
          cyc();
        end
        check("rr.gap_cycles", 32'(low), 32'd1);
      end
    end
    tick(); req_v[0] = 4'b0000; settle();
    cyc();

    // Abort: master 0 drops its request one cycle into BUSY.
    lat[0] = 4;
    tick(); req_v[0] = 4'b0001; addr_v[0][0] = 32'h1234_5670; settle();
    wait_grant(0);
    check("abort.owner", 32'(owner[0]), 32'd0);
    tick(); req_v[0] = 4'b0000; settle();
    begin
      bit saw;
      saw = 1'b0;
      for (int c = 0; c < 10; c++) begin
        check("abort.dn_req",  32'(dn_req[0]), 32'd1);
        check("abort.dn_addr", dn_addr[0],     32'h1234_5670);
        check("abort.no_ack",  32'(ack0),      32'd0);
        if (ack_v[0]) begin
          saw = 1'b1;
          break;
        end
        cyc();
      end
      check("abort.dcache_acked", 32'(saw), 32'd1);
    end
    cyc();
    check("abort.idle", 32'(busy[0]), 32'd0);

    // Fixed priority on u1: 1 beats 3; 1 re-requests only after 3 has started.
    lat[1] = 2;
    tick();
    req_v[1] = 4'b1010; addr_v[1][1] = 32'h1111_1110; addr_v[1][3] = 32'h3333_3330;
    settle();
    wait_grant(1);
    check("fixed.first_owner", 32'(owner[1]), 32'd1);
    check("fixed.first_addr",  dn_addr[1],    32'h1111_1110);
    wait_ack(1);
    check("fixed.first_ack", 32'(ack1), 32'h2);
    tick(); req_v[1] = 4'b1000; settle();
    wait_grant(1);
    check("fixed.second_owner", 32'(owner[1]), 32'd3);
    tick(); req_v[1] = 4'b1010; settle();
    wait_ack(1);
    check("fixed.second_ack", 32'(ack1), 32'h8);
    tick(); req_v[1] = 4'b0010; settle();
    wait_grant(1);
    check("fixed.third_owner", 32'(owner[1]), 32'd1);
    wait_ack(1);
    tick(); req_v[1] = 4'b0000; settle();
    cyc();

    // N=3: address held while BUSY, then the pointer wraps from 2 back to 0.
    lat[2] = 3;
    tick(); req_v[2] = 4'b0100; addr_v[2][2] = 32'hAAAA_0000; settle();
    wait_grant(2);
    check("n3.owner", 32'(owner[2]), 32'd2);
    tick(); addr_v[2][2] = 32'hBBBB_0000; settle();
    check("n3.addr_stable", dn_addr[2], 32'hAAAA_0000);
    wait_ack(2);
    check("n3.ack", 32'(ack2), 32'h4);
    tick(); req_v[2] = 4'b0111; settle();
    for (int t = 0; t < 4; t++) begin
      wait_grant(2);
      check("n3.wrap_owner", 32'(owner[2]), 32'(t % 3));
      wait_ack(2);
      check("n3.wrap_ack", 32'(ack2), 32'(1 << (t % 3)));
      if (t < 3) cyc();
    end
    tick(); req_v[2] = 4'b0000; settle();
    cyc();

    // Random phase: masters raise, hold, abandon and re-request at will.
    rand_mode = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < n_of(i); j++) begin
          logic b;
          b = req_v[i][j];
          if (b) begin
            if ($urandom_range(0, 15) == 0 || (samp_ack[i][j] && $urandom_range(0, 3) != 0)) b = 1'b0;
          end else if ($urandom_range(0, 3) == 0) begin
            b = 1'b1;
            addr_v[i][j] = $urandom() & 32'hFFFF_FFF8;
          end
          if ($urandom_range(0, 15) == 0) addr_v[i][j] = $urandom();
          req_v[i][j] = b;
        end
      end
      settle();
    end
    rand_mode = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) req_v[i] = '0;
    settle();
    for (int k = 0; k < 10; k++) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ptw_rr_arbiter.md
# ptw_rr_arbiter

Parametrised N-master arbiter that multiplexes page-table-walk read requests from several MMU-side masters (IMMU, DMMU, future hardware prefetch walker) onto the single PTW port of the DCache. Successor to the two-master fixed-priority PTW arbiter:
- generalises master count and widths;
- adds selectable round-robin or fixed priority;
- locks per transaction, from grant to downstream ack;
- guarantees a downstream request gap between transactions;
- handles masters that abandon a request mid-walk without corrupting the DCache handshake.

## Interface
Parameters:
- NUM_MASTERS, 2, number of masters (2..8); index 0 highest priority in fixed mode.
- ADDR_WIDTH, 32, PTE address width.
- DATA_WIDTH, 32, PTE data width.
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- up_req_i  in  NUM_MASTERS  per-master request level.
- up_addr_i  in  NUM_MASTERS×ADDR_WIDTH  per-master PTE address, packed.
- up_data_o  out  DATA_WIDTH  DCache data, broadcast to all masters.
- up_ack_o  out  NUM_MASTERS  one-hot per-master ack pulse.
- dn_req_o  out  1  request to DCache.
- dn_addr_o  out  ADDR_WIDTH  address to DCache.
- dn_data_i  in  DATA_WIDTH  DCache read data, valid with dn_ack_i.
- dn_ack_i  in  1  DCache ack, single-cycle pulse.
- owner_o  out  $clog2(NUM_MASTERS)  index of the current owner; 0 when idle.
- busy_o  out  1  a transaction is outstanding.

## Operation
- States: IDLE and BUSY.
- IDLE:
  - dn_req_o = 0.
  - If any up_req_i bit is set, pick a winner, latch owner_q and addr_q = up_addr_i[winner], clear abort_q, and go to BUSY.
- Winner selection:
  - Fixed mode: lowest set index wins.
  - Round-robin mode: the first set index at or after rr_ptr, searching upward with wrap modulo NUM_MASTERS.
- BUSY:
  - dn_req_o = 1 and dn_addr_o = addr_q, held stable until ack.
  - Later changes on up_addr_i are ignored.
- Abort: if up_req_i[owner_q] is 0 in any BUSY cycle, set abort_q. The downstream request stays asserted, because the DCache cannot cancel a request.
- dn_ack_i in BUSY:
  - up_ack_o[owner_q] = ~abort_q, combinational in the same cycle; all other ack bits are 0.
  - Next state is IDLE.
  - rr_ptr ← (owner_q + 1) mod NUM_MASTERS, in round-robin mode only.
- dn_ack_i in IDLE is a protocol error: ignore it, with no up_ack_o.
- up_data_o = dn_data_i, combinational and unqualified. A master samples it only on its own ack.
- Master rule: a master deasserts up_req_i by the cycle after its ack unless it is issuing a new request. A request still high in IDLE is treated as new.
- Simultaneous events:
  - A new request arriving in the ack cycle is seen in the following IDLE cycle.
  - An abort in the ack cycle suppresses that ack.

## Timing
- Reset values: dn_req_o = 0, dn_addr_o = 0, up_ack_o = 0, owner_o = 0, busy_o = 0, state IDLE, rr_ptr = 0, abort_q = 0.
- Reset mid-transaction drops everything. Any DCache ack arriving after reset lands in IDLE and is ignored.
- Grant latency: up_req_i rising in cycle t gives dn_req_o = 1 in t+1.
- Ack: same-cycle passthrough, with no added latency.
- Gap: dn_req_o is 0 for at least one cycle (IDLE) between consecutive transactions.
- Minimum transaction: the DCache acks no earlier than the cycle after dn_req_o rises.
- busy_o = (state == BUSY). owner_o = owner_q while BUSY, else 0.
- rr_ptr wrap: NUM_MASTERS−1 + 1 → 0. Widths are sized by $clog2, so non-power-of-two N must wrap explicitly with a compare, not by truncation.

## Structure
- Package ptw_arb_pkg holds:
  - the state enum (IDLE, BUSY);
  - an IDX_W helper function (max(1, $clog2(N))).
- Sub-module ptw_rr_picker: combinational, parametrised by N.
  - Inputs: req vector, rr_ptr, RR_MODE.
  - Outputs: winner index, any_req.
  - Implemented as a double-width masked priority encoder.
- The top level holds the FSM, the address/owner/abort registers and rr_ptr.

## Test plan
- Reset/idle: assert rst mid-BUSY with N=4 → all outputs 0 next edge; a late dn_ack_i produces no up_ack_o.
- Single transaction:
  - Stimulus: master 2 requests addr 0x8000_1000; DCache acks 3 cycles later with data 0xDEAD_BEEF.
  - Response: dn_req_o in t+1, up_ack_o = 4'b0100 in the ack cycle only, up_data_o = 0xDEAD_BEEF.
- Round-robin fairness:
  - Stimulus: all 4 masters hold requests continuously, each acked after 2 cycles.
  - Response: grant order 0,1,2,3,0; dn_req_o low for 1 cycle between transactions.
- Fixed mode (RR_MODE=0): masters 1 and 3 both request → master 1 is served first, then master 3 (1 re-requests only after 3 starts).
- Abort: master 0 drops its request 1 cycle into BUSY → dn_req_o stays high with the same address until ack; up_ack_o remains 0; then IDLE.
- Address stability / N=3 wrap: master 2 changes up_addr_i mid-BUSY → dn_addr_o is unchanged; after master 2's ack, rr_ptr = 0.
